// File: rtl/imem_arbiter.sv
// Arbiter and sequencer for the shared instruction memory port: fetch (read-only)
// and loader/debug (read/write), with a bounded fetch streak and 1-cycle responses.
module imem_arbiter #(
    parameter int unsigned MEM_SIZE         = 4095,
    parameter int unsigned MAX_FETCH_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [63:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        l_req,
    input  logic        l_we,
    input  logic [63:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        l_err,
    output logic [63:0] m_addr,
    output logic        m_we,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam int unsigned STREAK_W  = $clog2(MAX_FETCH_STREAK + 1);
    localparam logic [63:0] LAST_WORD = 64'(MEM_SIZE) - 64'd4;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_FETCH_STREAK);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_LOAD
    } owner_e;

    owner_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                f_legal, l_legal;

    // Full-width compare so addresses near 2^64 cannot wrap into range.
    function automatic logic addr_legal(input logic [63:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST_WORD);
    endfunction

    assign f_legal = addr_legal(f_addr);
    assign l_legal = addr_legal(l_addr);

    // Grant selection and memory port drive
    always_comb begin
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        if (reset) begin
            if (l_req && (!f_req || streak_q == STREAK_MAX)) begin
                l_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end
        m_addr  = f_gnt ? f_addr : (l_gnt ? l_addr : 64'd0);
        m_wdata = l_gnt ? l_wdata : 32'd0;
        m_we    = l_gnt && l_we && l_legal;
    end

    // Next response owner/payload and streak update
    always_comb begin
        state_d  = OWN_NONE;
        rdata_d  = 32'd0;
        err_d    = 1'b0;
        streak_d = streak_q;
        if (f_gnt) begin
            state_d = OWN_FETCH;
            err_d   = !f_legal;
            rdata_d = f_legal ? m_rdata : 32'd0;
        end else if (l_gnt) begin
            state_d = OWN_LOAD;
            err_d   = !l_legal;
            rdata_d = (l_legal && !l_we) ? m_rdata : 32'd0;
        end
        if (!l_req || l_gnt) begin
            streak_d = '0;
        end else if (f_gnt && streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= OWN_NONE;
            streak_q <= '0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Only the owner of the response sees payload; the other side reads zero.
    always_comb begin
        f_rvalid = (state_q == OWN_FETCH);
        l_rvalid = (state_q == OWN_LOAD);
        f_rdata  = f_rvalid ? rdata_q : 32'd0;
        f_err    = f_rvalid && err_q;
        l_rdata  = l_rvalid ? rdata_q : 32'd0;
        l_err    = l_rvalid && err_q;
    end

endmodule
